snake_status_tx: RTL



---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_status_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the Snake game: status packet layout, flag bits and
// the status transmitter state encoding.
package snake_pkg;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
  localparam int         PKT_LEN         = 7;

  localparam logic [2:0] IDX_HEADER   = 3'd0;
  localparam logic [2:0] IDX_SCORE_HI = 3'd1;
  localparam logic [2:0] IDX_SCORE_LO = 3'd2;
  localparam logic [2:0] IDX_HEAD_X   = 3'd3;
  localparam logic [2:0] IDX_HEAD_Y   = 3'd4;
  localparam logic [2:0] IDX_FLAGS    = 3'd5;
  localparam logic [2:0] IDX_CHECKSUM = 3'd6;

  localparam int FLAG_GAMEOVER = 0;
  localparam int FLAG_PAUSED   = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  function automatic logic [7:0] make_flags(input logic paused, input logic game_over);
    logic [7:0] f;
    f = 8'h00;
    f[FLAG_PAUSED]   = paused;
    f[FLAG_GAMEOVER] = game_over;
    return f;
  endfunction

endpackage

// File: rtl/snake_status_tx.sv
// Serializes a latched game-status snapshot into a 7-byte packet and drives
// the byte-level TxStart/TxReady handshake of UartTx.
module snake_status_tx
  import snake_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        SnapValid,
  output logic        SnapReady,
  input  logic [15:0] SnapScore,
  input  logic [7:0]  SnapHeadX,
  input  logic [7:0]  SnapHeadY,
  input  logic        SnapGameOver,
  input  logic        SnapPaused,
  output logic [7:0]  TxData,
  output logic        TxStart,
  input  logic        TxReady,
  output logic        Busy,
  output logic        PacketDone
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

  tx_state_t   state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic [15:0] score_reg, score_next;
  logic [7:0]  headx_reg, headx_next;
  logic [7:0]  heady_reg, heady_next;
  logic [7:0]  flags_reg, flags_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_start_reg, tx_start_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        ready_reg, ready_next;
  logic [7:0]  checksum;
  logic [7:0]  cur_byte;
  logic        capture;

  // Checksum covers only the latched payload, never the header.
  assign checksum = CHECKSUM_EN ?
                    (score_reg[15:8] ^ score_reg[7:0] ^ headx_reg ^ heady_reg ^ flags_reg) :
                    8'h00;

  assign capture = SnapValid && ready_reg && (state_reg == IDLE);

  always_comb begin
    cur_byte = 8'h00;
    case (idx_reg)
      IDX_HEADER:   cur_byte = HEADER_BYTE;
      IDX_SCORE_HI: cur_byte = score_reg[15:8];
      IDX_SCORE_LO: cur_byte = score_reg[7:0];
      IDX_HEAD_X:   cur_byte = headx_reg;
      IDX_HEAD_Y:   cur_byte = heady_reg;
      IDX_FLAGS:    cur_byte = flags_reg;
      IDX_CHECKSUM: cur_byte = checksum;
      default:      cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    score_next    = score_reg;
    headx_next    = headx_reg;
    heady_next    = heady_reg;
    flags_next    = flags_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (capture) begin
          score_next = SnapScore;
          headx_next = SnapHeadX;
          heady_next = SnapHeadY;
          flags_next = make_flags(SnapPaused, SnapGameOver);
          idx_next   = IDX_HEADER;
          busy_next  = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (TxReady) begin
          tx_data_next  = cur_byte;
          tx_start_next = 1'b1;
          state_next    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!TxReady) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (TxReady) begin
          if (idx_reg == LAST_IDX) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // An out-of-range index can only come from corruption; abandon the packet.
    if (state_reg != IDLE && idx_reg > LAST_IDX) begin
      state_next    = IDLE;
      idx_next      = 3'd0;
      busy_next     = 1'b0;
      tx_start_next = 1'b0;
    end

    ready_next = (state_next == IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'd0;
      score_reg    <= 16'h0000;
      headx_reg    <= 8'h00;
      heady_reg    <= 8'h00;
      flags_reg    <= 8'h00;
      tx_data_reg  <= 8'h00;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      score_reg    <= score_next;
      headx_reg    <= headx_next;
      heady_reg    <= heady_next;
      flags_reg    <= flags_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      ready_reg    <= ready_next;
    end
  end

  assign SnapReady  = ready_reg;
  assign TxData     = tx_data_reg;
  assign TxStart    = tx_start_reg;
  assign Busy       = busy_reg;
  assign PacketDone = done_reg;

endmodule
